// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter
// Round-robin arbiter that shares one parallel-load register between
// N_REQ requesters. It latches the winner's data, pulses the register load
// for one cycle, optionally reads the register back, then acknowledges the winner.
//
// Build option: define REG_ARB_VERIFY_EN to include the readback VERIFY
// state and the sticky err flag. When it is not defined, LOAD goes straight
// to DONE, err_o is tied low, and reg_q_i/err_clr_i are ignored.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a request; arbitrates and latches the winner
// S_LOAD   | reg_load_o high for one cycle with reg_d_o = held data
// S_VERIFY | compares the register readback with the held data
// S_DONE   | one-cycle ack to the winner; winner becomes the new "last"

module reg_load_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int W     = 4,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [N_REQ*W-1:0]   req_data_i,
  output logic [N_REQ-1:0]     ack_o,
  output logic [IW-1:0]        grant_id_o,
  output logic                 busy_o,
  output logic [W-1:0]         reg_d_o,
  output logic                 reg_load_o,
  input  logic [W-1:0]         reg_q_i,
  output logic                 err_o,
  input  logic                 err_clr_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  last_q, last_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [W-1:0]   hold_q, hold_d;

  logic           pick_valid;
  logic [IW-1:0]  pick_id;
  logic [W-1:0]   pick_data;
  logic           hi_valid;
  logic [IW-1:0]  hi_id;
  logic [IW-1:0]  lo_id;

  // Round-robin pick: lowest requester above "last" wins; otherwise wrap
  // around to the lowest requester overall.
  always_comb begin
    hi_valid   = 1'b0;
    hi_id      = '0;
    lo_id      = '0;
    pick_valid = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        pick_valid = 1'b1;
        lo_id      = IW'(i);
      end
      if (req_i[i] && (IW'(i) > last_q)) begin
        hi_valid = 1'b1;
        hi_id    = IW'(i);
      end
    end
    pick_id = hi_valid ? hi_id : lo_id;
  end

  // Data mux for the selected requester.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == pick_id) begin
        pick_data = req_data_i[i*W +: W];
      end
    end
  end

  // Next-state logic; requests are only looked at in S_IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_id;
          hold_d  = pick_data;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
`ifdef REG_ARB_VERIFY_EN
        state_d = S_VERIFY;
`else
        state_d = S_DONE;
`endif
      end
      S_VERIFY: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and transaction registers; last starts at N_REQ-1 so requester 0
  // has first priority after reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      last_q  <= IW'(N_REQ - 1);
      grant_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
    end
  end

  // Moore outputs decoded from state; reg_d_o is the held data at all times
  // so it is stable around the load pulse.
  always_comb begin
    ack_o = '0;
    if (state_q == S_DONE) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (IW'(i) == grant_q) begin
          ack_o[i] = 1'b1;
        end
      end
    end
  end

  assign grant_id_o = grant_q;
  assign busy_o     = (state_q != S_IDLE);
  assign reg_load_o = (state_q == S_LOAD);
  assign reg_d_o    = hold_q;

`ifdef REG_ARB_VERIFY_EN
  logic err_q, err_d;

  // Sticky readback-mismatch flag; a clear wins over a same-cycle mismatch.
  always_comb begin
    err_d = err_q;
    if (err_clr_i) begin
      err_d = 1'b0;
    end else if ((state_q == S_VERIFY) && (reg_q_i != hold_q)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  // Readback path is not built; keep the inputs visibly consumed.
  logic unused_verify_in;
  assign unused_verify_in = ^{reg_q_i, err_clr_i};
  assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Testbench for reg_load_arbiter. Honours REG_ARB_VERIFY_EN the same way as
// the design: with it defined a transaction is 4 cycles and err is checked.
`timescale 1ns/1ps

module tb_reg_load_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic [IW-1:0]  grant_id;
  logic           busy;
  logic [W-1:0]   reg_d;
  logic           reg_load;
  logic [W-1:0]   reg_q;
  logic           err;
  logic           err_clr;

  logic [W-1:0]   data_m [N];
  logic [W-1:0]   reg_q_r = '0;
  logic           corrupt;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   last_m;
  logic err_exp;

  reg_load_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .req_i      (req),
    .req_data_i (req_data),
    .ack_o      (ack),
    .grant_id_o (grant_id),
    .busy_o     (busy),
    .reg_d_o    (reg_d),
    .reg_load_o (reg_load),
    .reg_q_i    (reg_q),
    .err_o      (err),
    .err_clr_i  (err_clr)
  );

  always #5 clk = ~clk;

  // The shared register the arbiter drives.
  always_ff @(posedge clk) begin
    if (reg_load) reg_q_r <= reg_d;
  end
  assign reg_q = corrupt ? '0 : reg_q_r;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = data_m[i];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration: first requester after the last winner, modulo N.
  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  // One full transaction. Called just after a clock edge with the DUT idle
  // and req already set up; returns one edge after the ack cycle.
  task automatic serve_one(input int win, input logic [W-1:0] dat, input bit keep,
                           input bit corrupt_v, input bit clr_v,
                           input logic [N-1:0] late, output int got_grant);
    logic [N-1:0] exp_ack;
    exp_ack      = '0;
    exp_ack[win] = 1'b1;
    step();
    got_grant = int'(grant_id);
    check_eq("load_pulse", reg_load, 1'b1);
    check_eq("load_reg_d", reg_d, dat);
    check_eq("load_grant", grant_id, win);
    check_eq("load_busy", busy, 1'b1);
    check_eq("load_ack", ack, '0);
    req = req | late;
    step();
`ifdef REG_ARB_VERIFY_EN
    check_eq("verify_load", reg_load, 1'b0);
    check_eq("verify_busy", busy, 1'b1);
    check_eq("verify_ack", ack, '0);
    corrupt = corrupt_v;
    err_clr = clr_v;
    if (clr_v) err_exp = 1'b0;
    else if (corrupt_v && (dat != '0)) err_exp = 1'b1;
    step();
    corrupt = 1'b0;
    err_clr = 1'b0;
`endif
    check_eq("done_ack", ack, exp_ack);
    check_eq("done_reg_q", reg_q_r, dat);
    check_eq("done_reg_d", reg_d, dat);
    check_eq("done_load", reg_load, 1'b0);
    check_eq("done_err", err, err_exp);
    last_m = win;
    step();
    check_eq("idle_ack", ack, '0);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_err", err, err_exp);
    if (!keep) req[win] = 1'b0;
  endtask

  task automatic serve_next(input bit keep, input bit corrupt_v, input bit clr_v,
                            input logic [N-1:0] late, output int got_grant);
    int win;
    win = rr_pick(req, last_m);
    got_grant = -1;
    if (win >= 0) serve_one(win, data_m[win], keep, corrupt_v, clr_v, late, got_grant);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_ack", ack, '0);
    check_eq("rst_grant", grant_id, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_reg_d", reg_d, '0);
    check_eq("rst_load", reg_load, 1'b0);
    check_eq("rst_err", err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    last_m  = N - 1;
    err_exp = 1'b0;
    step();
  endtask

  initial begin
    int g;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] newm;
    logic [N-1:0] late;
    bit cv;
    bit clv;

    rst = 1'b1;
    req = '0;
    corrupt = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < N; i++) data_m[i] = '0;
    last_m = N - 1;
    err_exp = 1'b0;
    @(negedge clk);
    do_reset();
    step();
    check_eq("idle_no_req_busy", busy, 1'b0);
    check_eq("idle_no_req_load", reg_load, 1'b0);

    // Single request from requester 2.
    data_m[2] = 4'hA;
    req = 4'b0100;
    serve_next(1'b0, 1'b0, 1'b0, '0, g);
    check_eq("single_grant", g, 2);

    // Round-robin with everyone requesting, fresh priority.
    do_reset();
    for (int i = 0; i < N; i++) data_m[i] = W'(i + 1);
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      serve_next(1'b1, 1'b0, 1'b0, '0, g);
      check_eq("rr_order", g, exp_order[n]);
    end
    req = '0;

    // Wrap-around: serve 3, then 0 and 3 request together.
    req = 4'b1000;
    serve_next(1'b0, 1'b0, 1'b0, '0, g);
    check_eq("wrap_first", g, 3);
    req = 4'b1001;
    serve_next(1'b0, 1'b0, 1'b0, '0, g);
    check_eq("wrap_second", g, 0);
    serve_next(1'b0, 1'b0, 1'b0, '0, g);
    check_eq("wrap_third", g, 3);

    // Late request: requester 1 rises while requester 0 is loading.
    data_m[0] = 4'h6;
    data_m[1] = 4'h9;
    req = 4'b0001;
    serve_next(1'b0, 1'b0, 1'b0, 4'b0010, g);
    check_eq("late_first", g, 0);
    serve_next(1'b0, 1'b0, 1'b0, '0, g);
    check_eq("late_served", g, 1);

    // Reset in the middle of a load.
    data_m[2] = 4'h3;
    req = 4'b0100;
    step();
    check_eq("midrst_in_load", reg_load, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_load", reg_load, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_ack", ack, '0);
    check_eq("midrst_reg_d", reg_d, '0);
    step();
    check_eq("midrst_hold_ack", ack, '0);
    rst = 1'b0;
    last_m = N - 1;
    err_exp = 1'b0;
    req = 4'b1111;
    serve_next(1'b0, 1'b0, 1'b0, '0, g);
    check_eq("midrst_priority", g, 0);
    req = '0;
    step();

`ifdef REG_ARB_VERIFY_EN
    // Readback error, stickiness, clear and clear-vs-mismatch priority.
    data_m[1] = 4'h5;
    req = 4'b0010;
    serve_next(1'b0, 1'b1, 1'b0, '0, g);
    step();
    step();
    check_eq("err_sticky", err, 1'b1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    err_exp = 1'b0;
    check_eq("err_cleared", err, 1'b0);
    req = 4'b0010;
    serve_next(1'b0, 1'b1, 1'b1, '0, g);
    check_eq("err_clr_priority", err, 1'b0);
`else
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_eq("err_tied_low", err, 1'b0);
`endif

    // Randomized traffic against the reference model.
    req = '0;
    for (int it = 0; it < 200; it++) begin
      newm = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 3) == 0) newm = '0;
      for (int i = 0; i < N; i++) begin
        if (newm[i] && !req[i]) data_m[i] = W'($urandom);
      end
      req = req | newm;
      if (req == '0) begin
        step();
        check_eq("rand_idle_busy", busy, 1'b0);
        check_eq("rand_idle_ack", ack, '0);
      end else begin
        late = N'($urandom_range(0, (1 << N) - 1)) & ~req;
        if ($urandom_range(0, 1) == 0) late = '0;
        for (int i = 0; i < N; i++) begin
          if (late[i]) data_m[i] = W'($urandom);
        end
`ifdef REG_ARB_VERIFY_EN
        cv  = ($urandom_range(0, 3) == 0);
        clv = ($urandom_range(0, 3) == 0);
`else
        cv  = 1'b0;
        clv = 1'b0;
`endif
        serve_next(1'b0, cv, clv, late, g);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
